mem_stage_lsu: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs. It turns load/store control (MemRead, MemWrite, DMType) and the ALU address into a req/ack data-memory transaction.
- Formats load data (byte/half extraction, sign/zero extension) and registers the writeback bundle for the MEM/WB stage.
- Raises a stall to hold EX/MEM and earlier stages while a memory access is outstanding.

---
 rtl/mem_stage_lsu_pkg.sv | 45 ++++
 rtl/mem_stage_lsu_load_fmt.sv | 37 +++
 rtl/mem_stage_lsu.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// Lane/enable helpers are used by both the top and the load formatter.
package mem_stage_lsu_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } lsu_state_e;

    // Undefined dmtype codes fall through to word behaviour everywhere.
    function automatic logic [3:0] store_be(input logic [2:0] dmtype, input logic [1:0] addr_lo);
        case (dmtype)
            DM_HALF, DM_HALF_U: return addr_lo[1] ? 4'b1100 : 4'b0011;
            DM_BYTE, DM_BYTE_U: return 4'b0001 << addr_lo;
            default:            return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] dmtype, input logic [31:0] wdata);
        case (dmtype)
            DM_HALF, DM_HALF_U: return {2{wdata[15:0]}};
            DM_BYTE, DM_BYTE_U: return {4{wdata[7:0]}};
            default:            return wdata;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] dmtype, input logic [1:0] addr_lo);
        case (dmtype)
            DM_HALF, DM_HALF_U: return addr_lo[0];
            DM_BYTE, DM_BYTE_U: return 1'b0;
            default:            return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_fmt.sv
// Load formatter: picks the byte/half lane from the read word and extends it.
// Half lanes use addr[1] only, so odd half addresses read the aligned half.
module lsu_load_fmt
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dmtype,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (dmtype)
            DM_HALF:   data = {{16{half_sel[15]}}, half_sel};
            DM_HALF_U: data = {16'h0000, half_sel};
            DM_BYTE:   data = {{24{byte_sel[7]}}, byte_sel};
            DM_BYTE_U: data = {24'h000000, byte_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory access, load formatting, MEM/WB register.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of issuing them.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    input  logic [4:0]    in_rd,
    input  logic          in_regwrite,
    input  logic          in_memwrite,
    input  logic          in_memread,
    input  logic [1:0]    in_wdsel,
    input  logic [2:0]    in_dmtype,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          wb_valid,
    output logic [4:0]    wb_rd,
    output logic          wb_regwrite,
    output logic [1:0]    wb_wdsel,
    output logic [DW-1:0] wb_alu,
    output logic [DW-1:0] wb_load,
    output logic          misalign
);

    lsu_state_e    state_reg, state_next;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [2:0]    dmtype_reg;
    logic [4:0]    rd_reg;
    logic          regwrite_reg, we_reg, read_reg;
    logic [1:0]    wdsel_reg;

    logic          wb_valid_next, wb_regwrite_next, misalign_next;
    logic [4:0]    wb_rd_next;
    logic [1:0]    wb_wdsel_next;
    logic [DW-1:0] wb_alu_next, wb_load_next, fmt_data;
    logic          mem_op, trap, latch_en, in_access;

    assign mem_op    = in_valid & (in_memread | in_memwrite);
    assign in_access = (state_reg == ST_ACCESS);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = mem_op & is_misaligned(in_dmtype, in_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_load_fmt u_fmt (
        .rdata   (mem_rdata),
        .addr_lo (addr_reg[1:0]),
        .dmtype  (dmtype_reg),
        .data    (fmt_data)
    );

    always_comb begin
        state_next       = state_reg;
        latch_en         = 1'b0;
        stall            = 1'b0;
        wb_valid_next    = 1'b0;
        wb_rd_next       = '0;
        wb_regwrite_next = 1'b0;
        wb_wdsel_next    = '0;
        wb_alu_next      = '0;
        wb_load_next     = '0;
        misalign_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (trap) begin
                    wb_valid_next = 1'b1;
                    wb_rd_next    = in_rd;
                    wb_wdsel_next = in_wdsel;
                    wb_alu_next   = in_addr;
                    misalign_next = 1'b1;
                end else if (mem_op) begin
                    latch_en   = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_ACCESS;
                end else begin
                    wb_valid_next    = in_valid;
                    wb_rd_next       = in_rd;
                    wb_regwrite_next = in_regwrite;
                    wb_wdsel_next    = in_wdsel;
                    wb_alu_next      = in_addr;
                end
            end
            ST_ACCESS: begin
                // Dropping stall in the ack cycle lets EX/MEM advance on the same edge.
                stall = !mem_ack;
                if (mem_ack) begin
                    state_next       = ST_IDLE;
                    wb_valid_next    = 1'b1;
                    wb_rd_next       = rd_reg;
                    wb_regwrite_next = regwrite_reg;
                    wb_wdsel_next    = wdsel_reg;
                    wb_alu_next      = addr_reg;
                    wb_load_next     = read_reg ? fmt_data : '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            dmtype_reg   <= '0;
            rd_reg       <= '0;
            regwrite_reg <= 1'b0;
            we_reg       <= 1'b0;
            read_reg     <= 1'b0;
            wdsel_reg    <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            wb_wdsel     <= '0;
            wb_alu       <= '0;
            wb_load      <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                addr_reg     <= in_addr;
                wdata_reg    <= in_wdata;
                dmtype_reg   <= in_dmtype;
                rd_reg       <= in_rd;
                regwrite_reg <= in_regwrite;
                we_reg       <= in_memwrite & ~in_memread;
                read_reg     <= in_memread;
                wdsel_reg    <= in_wdsel;
            end
            wb_valid    <= wb_valid_next;
            wb_rd       <= wb_rd_next;
            wb_regwrite <= wb_regwrite_next;
            wb_wdsel    <= wb_wdsel_next;
            wb_alu      <= wb_alu_next;
            wb_load     <= wb_load_next;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_reg;
    always_ff @(posedge clk) begin
        if (rst) misalign_reg <= 1'b0;
        else     misalign_reg <= misalign_next;
    end
    assign misalign = misalign_reg;
`else
    assign misalign = 1'b0;
`endif

    // Bus outputs are quiet outside ACCESS so a reset or idle cycle shows all zeros.
    assign mem_req   = in_access;
    assign mem_we    = in_access & we_reg;
    assign mem_addr  = in_access ? {addr_reg[AW-1:2], 2'b00} : '0;
    assign mem_be    = !in_access ? 4'b0000 :
                       we_reg     ? store_be(dmtype_reg, addr_reg[1:0]) : 4'b1111;
    assign mem_wdata = (in_access & we_reg) ? store_data(dmtype_reg, wdata_reg) : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, back-to-back ops, reset abort, misalign option.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_regwrite, in_memwrite, in_memread;
    logic [31:0] in_addr, in_wdata, mem_rdata;
    logic [4:0]  in_rd;
    logic [1:0]  in_wdsel;
    logic [2:0]  in_dmtype;
    logic        mem_ack;
    logic        stall, mem_req, mem_we, wb_valid, wb_regwrite, misalign;
    logic [31:0] mem_addr, mem_wdata, wb_alu, wb_load;
    logic [3:0]  mem_be;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_wdsel;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_memwrite(in_memwrite), .in_memread(in_memread),
        .in_wdsel(in_wdsel), .in_dmtype(in_dmtype),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_wdsel(wb_wdsel),
        .wb_alu(wb_alu), .wb_load(wb_load), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to mid-cycle to sample combinational outputs.
    task automatic mid();
        #3;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic mw, input logic mr,
                         input logic [1:0] ws, input logic [2:0] dt);
        in_valid = v; in_addr = a; in_wdata = wd; in_rd = rd; in_regwrite = rw;
        in_memwrite = mw; in_memread = mr; in_wdsel = ws; in_dmtype = dt;
    endtask

    task automatic bubble();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        bubble();
        tick(); tick();
        rst = 1'b0;
        mid();
        n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_ctl got stall=%b req=%b we=%b exp 0", stall, mem_req, mem_we); end
        n_cmp++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus got addr=%h be=%b wd=%h exp 0", mem_addr, mem_be, mem_wdata); end
        n_cmp++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_regwrite !== 1'b0 || wb_wdsel !== 2'b00 || wb_alu !== 32'h0 || wb_load !== 32'h0 || misalign !== 1'b0) begin n_fail++; $display("FAIL reset_wb got v=%b rd=%0d alu=%h load=%h mis=%b exp 0", wb_valid, wb_rd, wb_alu, wb_load, misalign); end
        $display("txn reset done");
    endtask

    task automatic test_load_byte();
        int stall_cnt;
        stall_cnt = 0;
        tick();
        drive(1'b1, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 2'b01, 3'b011);
        mid();
        if (stall === 1'b1) stall_cnt++;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lb_req_idle got=%b exp=0", mem_req); end
        tick(); mid();
        if (stall === 1'b1) stall_cnt++;
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111 || mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lb_bus got req=%b we=%b be=%b addr=%h exp 1 0 1111 00001000", mem_req, mem_we, mem_be, mem_addr); end
        tick(); mid();
        if (stall === 1'b1) stall_cnt++;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        mid();
        if (stall === 1'b1) stall_cnt++;
        n_cmp++; if (stall_cnt !== 3) begin n_fail++; $display("FAIL lb_stall_cycles got=%0d exp=3", stall_cnt); end
        tick();
        mem_ack = 1'b0; bubble();
        n_cmp++; if (wb_valid !== 1'b1 || wb_load !== 32'hFFFF_FF80 || wb_rd !== 5'd5 || wb_regwrite !== 1'b1 || wb_alu !== 32'h0000_1003 || wb_wdsel !== 2'b01) begin n_fail++; $display("FAIL lb_wb got v=%b load=%h rd=%0d rw=%b alu=%h ws=%b exp 1 ffffff80 5 1 00001003 01", wb_valid, wb_load, wb_rd, wb_regwrite, wb_alu, wb_wdsel); end
        $display("txn LB addr=00001003 wb_load=%h", wb_load);
        tick();
        n_cmp++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL lb_one_shot got v=%b req=%b exp 0 0", wb_valid, mem_req); end
    endtask

    task automatic test_store();
        logic [31:0] s_addr [2];
        logic [31:0] s_wd   [2];
        logic [2:0]  s_dt   [2];
        logic [3:0]  e_be   [2];
        logic [31:0] e_wd   [2];
        logic [31:0] e_addr [2];
        s_addr[0] = 32'h0000_2002; s_wd[0] = 32'h0000_ABCD; s_dt[0] = 3'b001; e_be[0] = 4'b1100; e_wd[0] = 32'hABCD_ABCD; e_addr[0] = 32'h0000_2000;
        s_addr[1] = 32'h0000_2001; s_wd[1] = 32'h0000_00A5; s_dt[1] = 3'b011; e_be[1] = 4'b0010; e_wd[1] = 32'hA5A5_A5A5; e_addr[1] = 32'h0000_2000;
        for (int i = 0; i < 2; i++) begin
            int stall_cnt;
            stall_cnt = 0;
            drive(1'b1, s_addr[i], s_wd[i], 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, s_dt[i]);
            mid();
            if (stall === 1'b1) stall_cnt++;
            tick();
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            mid();
            if (stall === 1'b1) stall_cnt++;
            n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== e_be[i] || mem_wdata !== e_wd[i] || mem_addr !== e_addr[i]) begin n_fail++; $display("FAIL st%0d_bus got req=%b we=%b be=%b wd=%h addr=%h exp 1 1 %b %h %h", i, mem_req, mem_we, mem_be, mem_wdata, mem_addr, e_be[i], e_wd[i], e_addr[i]); end
            n_cmp++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL st%0d_stall_cycles got=%0d exp=1", i, stall_cnt); end
            tick();
            mem_ack = 1'b0; bubble();
            n_cmp++; if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL st%0d_wb got v=%b rw=%b req=%b exp 1 0 0", i, wb_valid, wb_regwrite, mem_req); end
            $display("txn ST%0d addr=%h be=%b", i, s_addr[i], e_be[i]);
        end
    endtask

    task automatic test_load_format();
        logic [31:0] l_addr [7];
        logic [2:0]  l_dt   [7];
        logic [31:0] l_exp  [7];
        l_addr[0] = 32'h0000_3002; l_dt[0] = 3'b010; l_exp[0] = 32'h0000_8001;
        l_addr[1] = 32'h0000_3000; l_dt[1] = 3'b000; l_exp[1] = 32'h8001_7FFF;
        l_addr[2] = 32'h0000_3000; l_dt[2] = 3'b001; l_exp[2] = 32'h0000_7FFF;
        l_addr[3] = 32'h0000_3002; l_dt[3] = 3'b001; l_exp[3] = 32'hFFFF_8001;
        l_addr[4] = 32'h0000_3001; l_dt[4] = 3'b100; l_exp[4] = 32'h0000_007F;
        l_addr[5] = 32'h0000_3000; l_dt[5] = 3'b011; l_exp[5] = 32'hFFFF_FFFF;
        l_addr[6] = 32'h0000_3000; l_dt[6] = 3'b111; l_exp[6] = 32'h8001_7FFF;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, l_addr[i], 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01, l_dt[i]);
            tick();
            mem_ack = 1'b1; mem_rdata = 32'h8001_7FFF;
            tick();
            mem_ack = 1'b0; bubble();
            n_cmp++; if (wb_valid !== 1'b1 || wb_load !== l_exp[i]) begin n_fail++; $display("FAIL ld%0d_fmt got v=%b load=%h exp 1 %h", i, wb_valid, wb_load, l_exp[i]); end
            $display("txn LD dt=%b addr=%h wb_load=%h", l_dt[i], l_addr[i], wb_load);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] seq;
        seq = '0;
        drive(1'b1, 32'h0000_0055, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
        mid();
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_add_stall got=%b exp=0", stall); end
        tick();
        seq[4] = wb_valid;
        n_cmp++; if (wb_alu !== 32'h0000_0055 || wb_rd !== 5'd3 || wb_load !== 32'h0) begin n_fail++; $display("FAIL b2b_add_wb got alu=%h rd=%0d load=%h exp 00000055 3 0", wb_alu, wb_rd, wb_load); end
        $display("txn ADD wb_alu=%h", wb_alu);
        drive(1'b1, 32'h0000_0010, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
        tick();
        seq[3] = wb_valid;
        mem_ack = 1'b1;
        mid();
        n_cmp++; if (mem_wdata !== 32'h1234_5678 || mem_be !== 4'b1111 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_sw_bus got wd=%h be=%b stall=%b exp 12345678 1111 0", mem_wdata, mem_be, stall); end
        tick();
        seq[2] = wb_valid;
        mem_ack = 1'b0;
        $display("txn SW addr=00000010");
        drive(1'b1, 32'h0000_0020, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000);
        tick();
        seq[1] = wb_valid;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        seq[0] = wb_valid;
        mem_ack = 1'b0; bubble();
        n_cmp++; if (wb_load !== 32'hDEAD_BEEF || wb_rd !== 5'd9 || wb_alu !== 32'h0000_0020) begin n_fail++; $display("FAIL b2b_lw_wb got load=%h rd=%0d alu=%h exp deadbeef 9 00000020", wb_load, wb_rd, wb_alu); end
        $display("txn LW addr=00000020 wb_load=%h", wb_load);
        n_cmp++; if (seq !== 5'b10101) begin n_fail++; $display("FAIL b2b_valid_seq got=%b exp=10101", seq); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup got=%b exp=0", wb_valid); end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 32'h0000_5004, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000);
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL abort_req_pre got=%b exp=1", mem_req); end
        rst = 1'b1; bubble();
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        mid();
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 || wb_valid !== 1'b0 || wb_alu !== 32'h0) begin n_fail++; $display("FAIL abort_outputs got req=%b stall=%b be=%b addr=%h v=%b alu=%h exp all 0", mem_req, stall, mem_be, mem_addr, wb_valid, wb_alu); end
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0 || wb_load !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_late_ack got v=%b load=%h req=%b exp 0 0 0", wb_valid, wb_load, mem_req); end
        drive(1'b1, 32'h0000_5008, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000);
        mid();
        n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_idle got stall=%b req=%b exp 1 0", stall, mem_req); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0; bubble();
        n_cmp++; if (wb_valid !== 1'b1 || wb_load !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL abort_recover got v=%b load=%h exp 1 0badf00d", wb_valid, wb_load); end
        $display("txn RESET-ABORT then LW addr=00005008");
    endtask

    task automatic test_misalign();
        logic saw_req;
        drive(1'b1, 32'h0000_4001, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000);
        mid();
`ifdef LSU_MISALIGN_TRAP_EN
        saw_req = mem_req;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall got=%b exp=0", stall); end
        tick();
        bubble();
        saw_req = saw_req | mem_req;
        n_cmp++; if (misalign !== 1'b1 || wb_valid !== 1'b1 || wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL mis_flag got mis=%b v=%b rw=%b exp 1 1 0", misalign, wb_valid, wb_regwrite); end
        tick();
        saw_req = saw_req | mem_req;
        n_cmp++; if (misalign !== 1'b0 || saw_req !== 1'b0) begin n_fail++; $display("FAIL mis_clear got mis=%b req_seen=%b exp 0 0", misalign, saw_req); end
        $display("txn LW-MISALIGNED addr=00004001 trapped");
`else
        saw_req = 1'b0;
        tick();
        saw_req = mem_req;
        n_cmp++; if (saw_req !== 1'b1 || mem_addr !== 32'h0000_4000 || misalign !== 1'b0) begin n_fail++; $display("FAIL mis_off_bus got req=%b addr=%h mis=%b exp 1 00004000 0", saw_req, mem_addr, misalign); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0123;
        tick();
        mem_ack = 1'b0; bubble();
        n_cmp++; if (wb_load !== 32'hCAFE_0123 || wb_regwrite !== 1'b1 || misalign !== 1'b0) begin n_fail++; $display("FAIL mis_off_wb got load=%h rw=%b mis=%b exp cafe0123 1 0", wb_load, wb_regwrite, misalign); end
        $display("txn LW-UNALIGNED addr=00004001 wb_load=%h", wb_load);
`endif
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store();
        test_load_format();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
